spi_sensor_responder: RTL and testbench

//   SPI mode-0 responder (slave) for read-only sensor frames: serves a FRAME_BITS-wide word,
//   MSB first, on MISO to an external master driving SCK/CS_N. It is the far end of the

---
 rtl/spi_sensor_responder.sv | 158 +++++++++++++++
 tb/tb_spi_sensor_responder.sv | 229 ++++++++++++++++++++++
 2 files changed

// File: rtl/spi_sensor_responder.sv
// SPI mode-0 responder serving read-only sensor frames MSB first on MISO.
// SCK and CS_N are oversampled in the clk_50 domain through synchroniser chains.
module spi_sensor_responder #(
   parameter int FRAME_BITS  = 16,
   parameter int SYNC_STAGES = 2,
   parameter int CNT_W       = 16
) (
   input  logic                  clk_50,
   input  logic                  reset_n,
   input  logic                  spi_sck,
   input  logic                  spi_cs_n,
   output logic                  spi_miso,
   output logic                  spi_miso_oe,
   input  logic [FRAME_BITS-1:0] load_data,
   input  logic                  load_valid,
   output logic                  load_ready,
   output logic                  frame_done,
   output logic                  frame_abort,
   output logic                  busy,
   output logic [CNT_W-1:0]      frame_count
);

   localparam int BC_W = $clog2(FRAME_BITS + 1);

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      ACTIVE = 2'd1,
      DONE   = 2'd2
   } state_t;

   state_t state;
   state_t state_next;

   logic [SYNC_STAGES-1:0] sck_sync;
   logic [SYNC_STAGES-1:0] cs_sync;
   logic                   sck_d;
   logic                   cs_d;
   logic                   sck_s;
   logic                   cs_s;
   logic                   sck_rise;
   logic                   sck_fall;
   logic                   cs_fall;
   logic                   cs_rise;

   logic [FRAME_BITS-1:0]  shift;
   logic [FRAME_BITS-1:0]  hold;
   logic [FRAME_BITS-1:0]  last_word;
   logic                   hold_valid;
   logic [BC_W-1:0]        bit_cnt;
   logic                   frame_start;

   // CS_N chain resets high so releasing reset never fabricates a select edge.
   always_ff @(posedge clk_50 or negedge reset_n) begin
      if (!reset_n) begin
         sck_sync <= '0;
         cs_sync  <= '1;
         sck_d    <= 1'b0;
         cs_d     <= 1'b1;
      end else begin
         sck_sync <= {sck_sync[SYNC_STAGES-2:0], spi_sck};
         cs_sync  <= {cs_sync[SYNC_STAGES-2:0], spi_cs_n};
         sck_d    <= sck_s;
         cs_d     <= cs_s;
      end
   end

   assign sck_s    = sck_sync[SYNC_STAGES-1];
   assign cs_s     = cs_sync[SYNC_STAGES-1];
   assign sck_rise = sck_s & ~sck_d;
   assign sck_fall = ~sck_s & sck_d;
   assign cs_fall  = ~cs_s & cs_d;
   assign cs_rise  = cs_s & ~cs_d;

   always_ff @(posedge clk_50 or negedge reset_n) begin
      if (!reset_n) begin
         state <= IDLE;
      end else begin
         state <= state_next;
      end
   end

   // A deselect outranks a coincident SCK rise: the frame is treated as aborted.
   always_comb begin
      state_next  = state;
      frame_done  = 1'b0;
      frame_abort = 1'b0;
      case (state)
         IDLE: begin
            if (cs_fall) begin
               state_next = ACTIVE;
            end
         end
         ACTIVE: begin
            if (cs_rise) begin
               state_next  = IDLE;
               frame_abort = 1'b1;
            end else if (sck_rise && bit_cnt == BC_W'(FRAME_BITS - 1)) begin
               state_next = DONE;
               frame_done = 1'b1;
            end
         end
         DONE: begin
            if (cs_rise) begin
               state_next = IDLE;
            end
         end
         default: state_next = IDLE;
      endcase
   end

   assign frame_start = (state == IDLE) && cs_fall;

   // An empty holding register lets a load arriving with the select edge bypass straight into shift.
   always_ff @(posedge clk_50 or negedge reset_n) begin
      if (!reset_n) begin
         shift       <= '0;
         hold        <= '0;
         last_word   <= '0;
         hold_valid  <= 1'b0;
         bit_cnt     <= '0;
         frame_count <= '0;
      end else begin
         if (frame_start) begin
            bit_cnt <= '0;
            if (hold_valid) begin
               shift      <= hold;
               last_word  <= hold;
               hold_valid <= 1'b0;
            end else if (load_valid) begin
               shift     <= load_data;
               last_word <= load_data;
            end else begin
               shift <= last_word;
            end
         end else begin
            if (load_valid && !hold_valid) begin
               hold       <= load_data;
               hold_valid <= 1'b1;
            end
            if (state != IDLE && sck_fall) begin
               shift <= {shift[FRAME_BITS-2:0], 1'b0};
            end
            if (state == ACTIVE && sck_rise) begin
               bit_cnt <= bit_cnt + 1'b1;
            end
         end
         if (frame_done) begin
            frame_count <= frame_count + 1'b1;
         end
      end
   end

   assign spi_miso_oe = ~cs_s && (state != IDLE);
   assign spi_miso    = spi_miso_oe & shift[FRAME_BITS-1];
   assign load_ready  = ~hold_valid;
   assign busy        = (state != IDLE);

endmodule

// File: tb/tb_spi_sensor_responder.sv
// Randomised SPI master driving spi_sensor_responder; a monitor checks frame events
// against a queue filled from a word-level model of the holding/repeat behaviour.
module tb_spi_sensor_responder;

   localparam int FB    = 16;
   localparam int SYNC  = 2;
   localparam int CW    = 16;
   localparam int HALF  = 8;

   logic          clk_50 = 1'b0;
   logic          reset_n;
   logic          spi_sck;
   logic          spi_cs_n;
   logic          spi_miso;
   logic          spi_miso_oe;
   logic [FB-1:0] load_data;
   logic          load_valid;
   logic          load_ready;
   logic          frame_done;
   logic          frame_abort;
   logic          busy;
   logic [CW-1:0] frame_count;

   spi_sensor_responder #(.FRAME_BITS(FB), .SYNC_STAGES(SYNC), .CNT_W(CW)) dut (
      .clk_50      (clk_50),
      .reset_n     (reset_n),
      .spi_sck     (spi_sck),
      .spi_cs_n    (spi_cs_n),
      .spi_miso    (spi_miso),
      .spi_miso_oe (spi_miso_oe),
      .load_data   (load_data),
      .load_valid  (load_valid),
      .load_ready  (load_ready),
      .frame_done  (frame_done),
      .frame_abort (frame_abort),
      .busy        (busy),
      .frame_count (frame_count)
   );

   always #10 clk_50 = ~clk_50;

   int checks = 0;
   int errors = 0;

   // Expected event: {is_abort, word served, frame_count after the event}.
   logic [32:0]   exp_q[$];
   logic [FB-1:0] rx_word;

   // Word-level model of the responder.
   logic [FB-1:0] m_hold;
   logic          m_hold_v;
   logic [FB-1:0] m_last;
   logic [CW-1:0] m_count;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
      end
   endtask

   logic [32:0]   mon_e;
   logic [CW-1:0] pend_count;
   logic          count_chk = 1'b0;

   always @(negedge clk_50) begin
      if (count_chk) begin
         check("frame_count_after_event", 32'(frame_count), 32'(pend_count));
         count_chk = 1'b0;
      end
      if (reset_n === 1'b1 && (frame_done === 1'b1 || frame_abort === 1'b1)) begin
         if (exp_q.size() == 0) begin
            check("unexpected_event", {30'd0, frame_done, frame_abort}, 32'd0);
         end else begin
            mon_e = exp_q.pop_front();
            check("event_is_abort", 32'(frame_abort), 32'(mon_e[32]));
            check("event_not_both", 32'(frame_done & frame_abort), 32'd0);
            if (!mon_e[32]) check("rx_word", 32'(rx_word), 32'(mon_e[31:16]));
            pend_count = mon_e[CW-1:0];
            count_chk  = 1'b1;
         end
      end
   end

   task automatic do_load(input logic [FB-1:0] w);
      check("load_ready_model", 32'(load_ready), 32'(!m_hold_v));
      if (!m_hold_v) begin
         @(negedge clk_50);
         load_data  = w;
         load_valid = 1'b1;
         @(negedge clk_50);
         load_valid = 1'b0;
         m_hold     = w;
         m_hold_v   = 1'b1;
      end
   endtask

   // Full frame when nbits >= FB, abort otherwise; bypass loads a word on the select edge.
   task automatic run_frame(input int nbits, input bit bypass, input logic [FB-1:0] bw);
      logic [FB-1:0] word;
      word     = bypass ? bw : (m_hold_v ? m_hold : m_last);
      m_last   = word;
      m_hold_v = 1'b0;
      if (nbits >= FB) begin
         m_count = m_count + 1'b1;
         exp_q.push_back({1'b0, word, m_count});
      end else begin
         exp_q.push_back({1'b1, word, m_count});
      end
      rx_word = '0;
      @(negedge clk_50);
      spi_cs_n = 1'b0;
      if (bypass) begin
         @(posedge clk_50);
         @(posedge clk_50);
         @(negedge clk_50);
         load_data  = bw;
         load_valid = 1'b1;
         @(negedge clk_50);
         load_valid = 1'b0;
         repeat (HALF - 2) @(negedge clk_50);
      end else begin
         repeat (HALF) @(negedge clk_50);
      end
      check("busy_selected", 32'(busy), 32'd1);
      check("oe_selected", 32'(spi_miso_oe), 32'd1);
      for (int i = 0; i < nbits; i++) begin
         if (i < FB) rx_word = {rx_word[FB-2:0], spi_miso};
         else check("extra_bit_zero", 32'(spi_miso), 32'd0);
         spi_sck = 1'b1;
         repeat (HALF) @(negedge clk_50);
         spi_sck = 1'b0;
         repeat (HALF) @(negedge clk_50);
      end
      spi_cs_n = 1'b1;
      repeat (SYNC + 2) @(posedge clk_50);
      @(negedge clk_50);
      check("busy_after_deselect", 32'(busy), 32'd0);
      check("oe_after_deselect", 32'(spi_miso_oe), 32'd0);
      check("miso_after_deselect", 32'(spi_miso), 32'd0);
      repeat (4) @(negedge clk_50);
   endtask

   initial begin
      int r;
      int nb;
      reset_n    = 1'b0;
      spi_sck    = 1'b0;
      spi_cs_n   = 1'b1;
      load_data  = '0;
      load_valid = 1'b0;
      m_hold     = '0;
      m_hold_v   = 1'b0;
      m_last     = '0;
      m_count    = '0;
      rx_word    = '0;
      repeat (5) @(negedge clk_50);
      check("rst_oe", 32'(spi_miso_oe), 32'd0);
      check("rst_miso", 32'(spi_miso), 32'd0);
      check("rst_load_ready", 32'(load_ready), 32'd1);
      check("rst_done", 32'(frame_done), 32'd0);
      check("rst_abort", 32'(frame_abort), 32'd0);
      check("rst_busy", 32'(busy), 32'd0);
      check("rst_count", 32'(frame_count), 32'd0);
      reset_n = 1'b1;
      repeat (3) @(negedge clk_50);

      do_load(16'hA5C3);
      check("load_ready_full", 32'(load_ready), 32'd0);
      run_frame(16, 1'b0, '0);
      check("load_ready_after_frame", 32'(load_ready), 32'd1);
      run_frame(16, 1'b0, '0);
      check("count_two", 32'(frame_count), 32'd2);

      do_load(16'h1234);
      run_frame(5, 1'b0, '0);
      check("count_after_abort", 32'(frame_count), 32'd2);
      run_frame(16, 1'b0, '0);

      do_load(16'hFFFF);
      run_frame(20, 1'b0, '0);

      run_frame(16, 1'b1, 16'h0F0F);
      check("bypass_load_ready", 32'(load_ready), 32'd1);

      for (int k = 0; k < 30; k++) begin
         if ($urandom_range(0, 1) == 1) do_load(16'($urandom));
         r = $urandom_range(0, 3);
         nb = (r == 0) ? $urandom_range(0, 15) : (r == 1) ? $urandom_range(17, 20) : 16;
         if (!m_hold_v && $urandom_range(0, 4) == 0) run_frame(nb, 1'b1, 16'($urandom));
         else run_frame(nb, 1'b0, '0);
      end

      // Reset in the middle of a frame.
      do_load(16'hBEEF);
      @(negedge clk_50);
      spi_cs_n = 1'b0;
      repeat (HALF) @(negedge clk_50);
      for (int i = 0; i < 3; i++) begin
         spi_sck = 1'b1;
         repeat (HALF) @(negedge clk_50);
         spi_sck = 1'b0;
         repeat (HALF) @(negedge clk_50);
      end
      check("mid_oe_before_reset", 32'(spi_miso_oe), 32'd1);
      #3 reset_n = 1'b0;
      #1;
      check("mid_rst_oe", 32'(spi_miso_oe), 32'd0);
      check("mid_rst_busy", 32'(busy), 32'd0);
      check("mid_rst_count", 32'(frame_count), 32'd0);
      check("mid_rst_load_ready", 32'(load_ready), 32'd1);
      m_hold_v = 1'b0;
      m_last   = '0;
      m_count  = '0;
      spi_cs_n = 1'b1;
      repeat (3) @(negedge clk_50);
      reset_n = 1'b1;
      repeat (3) @(negedge clk_50);
      run_frame(16, 1'b0, '0);
      check("count_after_reset_frame", 32'(frame_count), 32'd1);

      repeat (5) @(negedge clk_50);
      check("queue_drained", 32'(exp_q.size()), 32'd0);
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
